// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO sequencer for the shared multiplier and divider.
// It accepts MULT/MULTU/DIV/DIVU, launches the selected unit with latched operands,
// stalls until the unit answers or times out, and commits the result to HI/LO.
// It also services MTHI/MTLO/MFHI/MFLO and rejects division by zero.
module hilo_muldiv_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        mul_valid_in,
    output logic        mul_sign,
    input  logic        mul_valid_out,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic        div_valid_in,
    output logic        div_sign,
    input  logic        div_valid_out,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        unit_abort,
    output logic        div_by_zero,
    output logic        timeout_err
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MUL_WAIT = 2'd1;
    localparam logic [1:0] DIV_WAIT = 2'd2;

    // Wait-cycle index at which a silent unit is abandoned (index 0 is the start cycle).
    localparam logic [6:0] LAST_WAIT = 7'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q;
    logic [6:0]  cnt_q;
    logic        start_q;
    logic        dbz_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] unit_a_q, unit_b_q;
    logic        mul_sign_q, div_sign_q;

    logic idle, is_mul, is_div, accept_mul, accept_div, div_zero;
    logic waiting, unit_done, timed_out, mt_hi, mt_lo;

    // Decode the request and the wait-state events.
    always_comb begin
        idle       = (state_q == IDLE);
        is_mul     = op_valid && (funct == F_MULT || funct == F_MULTU);
        is_div     = op_valid && (funct == F_DIV || funct == F_DIVU);
        accept_mul = idle && is_mul;
        div_zero   = idle && is_div && (src_b == 32'd0);
        accept_div = idle && is_div && (src_b != 32'd0);
        mt_hi      = idle && op_valid && (funct == F_MTHI);
        mt_lo      = idle && op_valid && (funct == F_MTLO);
        waiting    = !idle;
        // valid_out is only honoured after the start-pulse cycle and from the active unit.
        unit_done  = !start_q &&
                     ((state_q == MUL_WAIT && mul_valid_out) ||
                      (state_q == DIV_WAIT && div_valid_out));
        // Completion takes priority over the timeout threshold.
        timed_out  = waiting && !unit_done && (cnt_q == LAST_WAIT);
    end

    // Drive the pipeline and unit-facing outputs.
    always_comb begin
        stall        = accept_mul || accept_div || (waiting && !unit_done && !timed_out);
        mul_valid_in = start_q && (state_q == MUL_WAIT);
        div_valid_in = start_q && (state_q == DIV_WAIT);
        unit_abort   = timed_out;
        timeout_err  = timed_out;
        div_by_zero  = dbz_q;
        hi           = hi_q;
        lo           = lo_q;
        unit_a       = unit_a_q;
        unit_b       = unit_b_q;
        mul_sign     = mul_sign_q;
        div_sign     = div_sign_q;
        mf_data      = 32'd0;
        if (op_valid && funct == F_MFHI) mf_data = hi_q;
        if (op_valid && funct == F_MFLO) mf_data = lo_q;
    end

    // Sequencer state, wait counter and one-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
            start_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            start_q <= accept_mul || accept_div;
            dbz_q   <= div_zero;
            if (accept_mul) begin
                state_q <= MUL_WAIT;
                cnt_q   <= 7'd0;
            end else if (accept_div) begin
                state_q <= DIV_WAIT;
                cnt_q   <= 7'd0;
            end else if (waiting && (unit_done || timed_out)) begin
                state_q <= IDLE;
            end else if (waiting) begin
                cnt_q <= cnt_q + 7'd1;
            end
        end
    end

    // Operand and sign latches, held stable for the whole wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unit_a_q   <= 32'd0;
            unit_b_q   <= 32'd0;
            mul_sign_q <= 1'b0;
            div_sign_q <= 1'b0;
        end else if (accept_mul || accept_div) begin
            unit_a_q <= src_a;
            unit_b_q <= src_b;
            if (accept_mul) mul_sign_q <= (funct == F_MULT);
            else            div_sign_q <= (funct == F_DIV);
        end
    end

    // Architectural HI/LO: unit commit or MTHI/MTLO write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (unit_done) begin
            hi_q <= (state_q == MUL_WAIT) ? mul_hi : div_hi;
            lo_q <= (state_q == MUL_WAIT) ? mul_lo : div_lo;
        end else begin
            if (mt_hi) hi_q <= src_a;
            if (mt_lo) lo_q <= src_a;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl; the bench plays both arithmetic units and
// keeps expected HI/LO results in a scoreboard queue.
module tb_hilo_muldiv_ctrl;

    localparam int unsigned TMO = 8;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b;
    logic        stall;
    logic [31:0] hi, lo, mf_data, unit_a, unit_b;
    logic        mul_valid_in, mul_sign, mul_valid_out;
    logic [31:0] mul_hi, mul_lo;
    logic        div_valid_in, div_sign, div_valid_out;
    logic [31:0] div_hi, div_lo;
    logic        unit_abort, div_by_zero, timeout_err;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hl_t;

    hl_t         sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] hi_ref, lo_ref;

    hilo_muldiv_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .funct(funct),
        .src_a(src_a), .src_b(src_b), .stall(stall), .hi(hi), .lo(lo),
        .mf_data(mf_data), .unit_a(unit_a), .unit_b(unit_b),
        .mul_valid_in(mul_valid_in), .mul_sign(mul_sign), .mul_valid_out(mul_valid_out),
        .mul_hi(mul_hi), .mul_lo(mul_lo),
        .div_valid_in(div_valid_in), .div_sign(div_sign), .div_valid_out(div_valid_out),
        .div_hi(div_hi), .div_lo(div_lo),
        .unit_abort(unit_abort), .div_by_zero(div_by_zero), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: hi = upper product / remainder, lo = lower product / quotient.
    function automatic hl_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        hl_t         r;
        p = 64'd0;
        r = '0;
        if (f == F_MULT) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r = {p[63:32], p[31:0]};
        end else if (f == F_MULTU) begin
            p = {32'd0, a} * {32'd0, b};
            r = {p[63:32], p[31:0]};
        end else if (f == F_DIV) begin
            r.lo = $signed(a) / $signed(b);
            r.hi = $signed(a) % $signed(b);
        end else begin
            r.lo = a / b;
            r.hi = a % b;
        end
        return r;
    endfunction

    task automatic drive_unit(input bit is_mul, input bit v, input logic [31:0] h,
                              input logic [31:0] l);
        if (is_mul) begin
            mul_valid_out = v; mul_hi = h; mul_lo = l;
        end else begin
            div_valid_out = v; div_hi = h; div_lo = l;
        end
    endtask

    // Issue one unit op; the unit answers lat cycles after its start pulse.
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input bit early);
        hl_t  e;
        int   stalls;
        bit   is_mul;
        logic sgn;
        is_mul = (f == F_MULT) || (f == F_MULTU);
        sgn    = (f == F_MULT) || (f == F_DIV);
        e      = model(f, a, b);
        @(negedge clk);
        op_valid = 1'b1; funct = f; src_a = a; src_b = b;
        #1;
        check("accept_stall", 64'(stall), 64'd1);
        stalls = int'(stall);
        sb_q.push_back(e);
        @(negedge clk);
        op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
        if (early) drive_unit(is_mul, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF);
        #1;
        check("start_pulse", 64'(is_mul ? mul_valid_in : div_valid_in), 64'd1);
        check("other_start", 64'(is_mul ? div_valid_in : mul_valid_in), 64'd0);
        check("sign", 64'(is_mul ? mul_sign : div_sign), 64'(sgn));
        check("unit_ops", {unit_a, unit_b}, {a, b});
        stalls += int'(stall);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            drive_unit(is_mul, 1'b0, 32'd0, 32'd0);
            drive_unit(!is_mul, 1'b1, 32'hBAD0BAD0, 32'hBAD0BAD0);
            #1;
            check("start_once", 64'(is_mul ? mul_valid_in : div_valid_in), 64'd0);
            stalls += int'(stall);
        end
        @(negedge clk);
        drive_unit(!is_mul, 1'b0, 32'd0, 32'd0);
        drive_unit(is_mul, 1'b1, e.hi, e.lo);
        #1;
        check("done_stall", 64'(stall), 64'd0);
        check("done_no_timeout", 64'(timeout_err), 64'd0);
        check("ops_held", {unit_a, unit_b}, {a, b});
        @(negedge clk);
        drive_unit(is_mul, 1'b0, 32'd0, 32'd0);
        #1;
        e = sb_q.pop_front();
        check("commit", {hi, lo}, e);
        check("stall_cycles", 64'(stalls), 64'(lat + 1));
        hi_ref = e.hi;
        lo_ref = e.lo;
    endtask

    initial begin
        int stalls;
        bit seen;
        reset = 1'b1; op_valid = 1'b0; funct = 6'd0; src_a = 32'd0; src_b = 32'd0;
        mul_valid_out = 1'b0; mul_hi = 32'd0; mul_lo = 32'd0;
        div_valid_out = 1'b0; div_hi = 32'd0; div_lo = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_starts", {62'd0, mul_valid_in, div_valid_in}, 64'd0);
        check("rst_pulses", {61'd0, unit_abort, timeout_err, div_by_zero}, 64'd0);
        check("rst_ops", {unit_a, unit_b}, 64'd0);
        reset = 1'b0;
        hi_ref = 32'd0;
        lo_ref = 32'd0;

        do_op(F_MULT, 32'hFFFFFFFD, 32'd5, 3, 1'b0);
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        do_op(F_MULTU, 32'hFFFFFFFF, 32'd2, 2, 1'b1);
        check("multu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);
        do_op(F_DIV, 32'd7, 32'hFFFFFFFE, 1, 1'b0);
        check("div_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);

        // Divide by zero: pulse next cycle, no stall, no launch.
        @(negedge clk);
        op_valid = 1'b1; funct = F_DIVU; src_a = 32'd9; src_b = 32'd0;
        #1;
        check("dbz_stall", 64'(stall), 64'd0);
        check("dbz_no_start0", 64'(div_valid_in), 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("dbz_pulse", 64'(div_by_zero), 64'd1);
        check("dbz_no_start1", 64'(div_valid_in), 64'd0);
        check("dbz_hilo", {hi, lo}, {hi_ref, lo_ref});
        @(negedge clk);
        #1;
        check("dbz_pulse_end", 64'(div_by_zero), 64'd0);
        check("dbz_no_start2", 64'(div_valid_in), 64'd0);

        // Move to / from HI and LO.
        @(negedge clk);
        op_valid = 1'b1; funct = F_MTHI; src_a = 32'h12345678;
        #1;
        check("mthi_stall", 64'(stall), 64'd0);
        @(negedge clk);
        funct = F_MFHI; src_a = 32'd0;
        #1;
        check("mfhi", 64'(mf_data), 64'h12345678);
        hi_ref = 32'h12345678;
        @(negedge clk);
        funct = F_MTLO; src_a = 32'hA5A5A5A5;
        @(negedge clk);
        funct = F_MFLO; src_a = 32'd0;
        #1;
        check("mflo", 64'(mf_data), 64'hA5A5A5A5);
        check("mtlo_hi_kept", 64'(hi), 64'(hi_ref));
        lo_ref = 32'hA5A5A5A5;
        @(negedge clk);
        funct = F_ADD; src_a = 32'h0BADF00D; src_b = 32'd0;
        #1;
        check("other_stall", 64'(stall), 64'd0);
        check("other_mf", 64'(mf_data), 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("other_hilo", {hi, lo}, {hi_ref, lo_ref});

        // Completion on the same cycle as the timeout threshold.
        do_op(F_DIVU, 32'd100, 32'd7, TMO - 1, 1'b0);
        check("divu_edge_hilo", {hi, lo}, {32'd2, 32'd14});

        // Unit never answers.
        @(negedge clk);
        op_valid = 1'b1; funct = F_MULT; src_a = 32'd3; src_b = 32'd4;
        #1;
        stalls = int'(stall);
        seen = 1'b0;
        @(negedge clk);
        op_valid = 1'b0;
        for (int k = 0; k < int'(TMO) + 4; k++) begin
            #1;
            if (timeout_err) begin
                seen = 1'b1;
                check("to_abort", 64'(unit_abort), 64'd1);
                check("to_stall_low", 64'(stall), 64'd0);
                break;
            end
            stalls += int'(stall);
            @(negedge clk);
        end
        check("to_seen", 64'(seen), 64'd1);
        check("to_stall_cycles", 64'(stalls), 64'(TMO));
        @(negedge clk);
        #1;
        check("to_pulse_end", {62'd0, timeout_err, unit_abort}, 64'd0);
        check("to_idle_stall", 64'(stall), 64'd0);
        check("to_hilo", {hi, lo}, {hi_ref, lo_ref});

        // Reset in the middle of a multiply wait.
        @(negedge clk);
        op_valid = 1'b1; funct = F_MULT; src_a = 32'd5; src_b = 32'd6;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_rst_stall", 64'(stall), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_stall", 64'(stall), 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        check("mid_rst_start", 64'(mul_valid_in), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_unit(1'b1, 1'b1, 32'h0000001E, 32'h0000001E);
        #1;
        check("idle_valid_stall", 64'(stall), 64'd0);
        @(negedge clk);
        drive_unit(1'b1, 1'b0, 32'd0, 32'd0);
        #1;
        check("idle_valid_hilo", {hi, lo}, 64'd0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
